// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM stream reader and its BRAM wrapper instance.
package bram_reader_pkg;

  localparam int BRAM_READ_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/sync_stream_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; output reads as zero when empty.
module sync_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full;

  // Explicit wrap compare keeps non-power-of-2 depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = rd_en && (count_q != '0);
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a run of BRAM words out as AXI-Stream beats, issuing one pipelined read per cycle
// while credit (free FIFO slots not already claimed by in-flight reads) remains.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DATA_DEPTH   = 2048,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int READ_LATENCY = BRAM_READ_LATENCY,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

  reader_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    bram_en_q, bram_en_d;
  logic                    bram_last_q, bram_last_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_WIDTH:0]     fifo_rd_data;
  logic                    fifo_rd_valid;
  logic                    pop;
  logic                    credit_ok;
  logic [CRD_W-1:0]        used;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [CRD_W-1:0] popcount(input logic [READ_LATENCY-1:0] v);
    logic [CRD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      acc = acc + CRD_W'(v[i]);
    end
    return acc;
  endfunction

  always_comb begin
    // The read currently on bram_en is not yet in the valid pipe, so it is counted separately.
    used        = CRD_W'(fifo_count) + popcount(vld_q) + CRD_W'(bram_en_q);
    credit_ok   = (used < CRD_W'(FIFO_DEPTH));
    pop         = fifo_rd_valid && m_axis_tready;
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    bram_en_d   = 1'b0;
    bram_last_d = 1'b0;
    bram_addr_d = bram_addr_q;
    case (state_q)
      IDLE: begin
        // Pipe and FIFO are empty here, so the first read needs no credit check.
        if (cmd_valid && (cmd_len != '0)) begin
          bram_en_d   = 1'b1;
          bram_addr_d = cmd_addr;
          addr_d      = addr_inc(cmd_addr);
          rem_d       = cmd_len - 1'b1;
          bram_last_d = (cmd_len == LEN_WIDTH'(1));
          state_d     = bram_last_d ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          bram_en_d   = 1'b1;
          bram_addr_d = addr_q;
          addr_d      = addr_inc(addr_q);
          rem_d       = rem_q - 1'b1;
          bram_last_d = (rem_q == LEN_WIDTH'(1));
          if (bram_last_d) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_rd_data[0]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    vld_d[0] = bram_en_q;
    lst_d[0] = bram_last_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_last_q <= 1'b0;
      bram_addr_q <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      bram_en_q   <= bram_en_d;
      bram_last_q <= bram_last_d;
      bram_addr_q <= bram_addr_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
    end
  end

  sync_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_q[READ_LATENCY-1]),
    .wr_data  ({bram_dout, lst_q[READ_LATENCY-1]}),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .count    (fifo_count)
  );

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bram_en       = bram_en_q;
  assign bram_addr     = bram_addr_q;
  assign m_axis_tvalid = fifo_rd_valid;
  assign m_axis_tdata  = fifo_rd_data[DATA_WIDTH:1];
  assign m_axis_tlast  = fifo_rd_data[0];

endmodule
